// File: rtl/sfx_pkg.sv
// Shared types and helpers for the sound-effect scheduler.
package sfx_pkg;

  typedef enum logic [1:0] {SFX_NONE, SFX_JUMP, SFX_WIN, SFX_LOSE} sfx_id_t;
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} sfx_state_t;

  // Pending-bit positions inside the 3-bit pend vector.
  localparam int unsigned PendJump = 0;
  localparam int unsigned PendWin  = 1;
  localparam int unsigned PendLose = 2;

  function automatic int unsigned sfx_max(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Highest-priority pending effect: LOSE > WIN > JUMP.
  function automatic sfx_id_t sfx_prio(logic [2:0] pend);
    if (pend[PendLose]) return SFX_LOSE;
    if (pend[PendWin])  return SFX_WIN;
    if (pend[PendJump]) return SFX_JUMP;
    return SFX_NONE;
  endfunction

endpackage

// File: rtl/sfx_scheduler_if.sv
// Game-event / generator-side signal bundle for sfx_scheduler.
// master: game logic and tone generators; slave: the scheduler.
interface sfx_scheduler_if;

  logic jump_forward;
  logic jump_backward;
  logic jump_right;
  logic jump_left;
  logic win;
  logic lose;
  logic mute;
  logic jump_sound_in;
  logic win_sound_in;
  logic lose_sound_in;
  logic enable_jump;
  logic enable_win;
  logic enable_lose;
  logic [1:0] active_id;
  logic busy;
  logic sound;

  modport master (
    output jump_forward, jump_backward, jump_right, jump_left, win, lose, mute,
    output jump_sound_in, win_sound_in, lose_sound_in,
    input  enable_jump, enable_win, enable_lose, active_id, busy, sound
  );

  modport slave (
    input  jump_forward, jump_backward, jump_right, jump_left, win, lose, mute,
    input  jump_sound_in, win_sound_in, lose_sound_in,
    output enable_jump, enable_win, enable_lose, active_id, busy, sound
  );

endinterface

// File: rtl/sfx_duration_timer.sv
// Loadable down-counter shared by the PLAY and GAP phases; saturates at zero.
module sfx_duration_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] count_q;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: edge-detects game events, pends them, plays one effect
// at a time by priority with a silent gap after each, and muxes the tone output.
// Optional feature macro: SFX_PREEMPT_EN (higher-priority pending effect aborts playback).
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int unsigned JUMP_CYCLES = 2_500_000,
  parameter int unsigned WIN_CYCLES  = 25_000_000,
  parameter int unsigned LOSE_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 250_000
) (
  input  logic clk,
  input  logic reset,
  sfx_scheduler_if.slave bus
);

  localparam int unsigned MaxDur =
    sfx_max(sfx_max(JUMP_CYCLES, WIN_CYCLES), sfx_max(LOSE_CYCLES, GAP_CYCLES));
  localparam int unsigned CntW = $clog2(MaxDur + 1);

`ifdef SFX_PREEMPT_EN
  localparam bit PreemptEn = 1'b1;
`else
  localparam bit PreemptEn = 1'b0;
`endif

  logic [3:0] dir_now, dir_q;
  logic       win_q, lose_q;
  logic       jump_evt, win_evt, lose_evt;

  sfx_state_t state_q, state_d;
  sfx_id_t    cur_q, cur_d;
  sfx_id_t    top;
  logic [2:0] pend_q, pend_d, pend_clr;
  logic       absorb_jump;
  logic       preempt;

  logic            tmr_load, tmr_dec, tmr_zero;
  logic [CntW-1:0] tmr_val;

  function automatic logic [CntW-1:0] dur_m1(sfx_id_t id);
    unique case (id)
      SFX_JUMP: return CntW'(JUMP_CYCLES - 1);
      SFX_WIN:  return CntW'(WIN_CYCLES - 1);
      SFX_LOSE: return CntW'(LOSE_CYCLES - 1);
      default:  return '0;
    endcase
  endfunction

  // Dispatching WIN or LOSE also discards a waiting jump.
  function automatic logic [2:0] clr_mask(sfx_id_t id);
    unique case (id)
      SFX_JUMP: return 3'b001;
      SFX_WIN:  return 3'b011;
      SFX_LOSE: return 3'b101;
      default:  return 3'b000;
    endcase
  endfunction

  assign dir_now  = {bus.jump_forward, bus.jump_backward, bus.jump_right, bus.jump_left};
  assign jump_evt = |(dir_now & ~dir_q);
  assign win_evt  = bus.win & ~win_q;
  assign lose_evt = bus.lose & ~lose_q;

  // Input history; reset also loads live levels so held inputs never look like events.
  always_ff @(posedge clk) begin
    dir_q  <= dir_now;
    win_q  <= bus.win;
    lose_q <= bus.lose;
  end

  sfx_duration_timer #(
    .Width (CntW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Next-state: dispatch, play/retrigger/preempt, gap, and pend bookkeeping.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    pend_clr    = '0;
    absorb_jump = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_dec     = 1'b0;
    top         = sfx_prio(pend_q);
    preempt     = PreemptEn && (top > cur_q);

    unique case (state_q)
      S_IDLE: begin
        if (top != SFX_NONE) begin
          state_d  = S_PLAY;
          cur_d    = top;
          tmr_load = 1'b1;
          tmr_val  = dur_m1(top);
          pend_clr = clr_mask(top);
        end
      end
      S_PLAY: begin
        if (preempt) begin
          cur_d    = top;
          tmr_load = 1'b1;
          tmr_val  = dur_m1(top);
          pend_clr = clr_mask(top);
        end else if (jump_evt && (cur_q == SFX_JUMP)) begin
          // Retrigger extends the running jump instead of queueing another.
          absorb_jump = 1'b1;
          tmr_load    = 1'b1;
          tmr_val     = CntW'(JUMP_CYCLES - 1);
        end else if (tmr_zero) begin
          state_d  = S_GAP;
          cur_d    = SFX_NONE;
          tmr_load = 1'b1;
          tmr_val  = CntW'(GAP_CYCLES - 1);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_GAP: begin
        if (tmr_zero) begin
          state_d = S_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cur_d   = SFX_NONE;
      end
    endcase

    // New events are applied after dispatch clears, so a same-edge event survives.
    pend_d = (pend_q & ~pend_clr) | {lose_evt, win_evt, jump_evt & ~absorb_jump};
  end

  // State, active effect and pend registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cur_q   <= SFX_NONE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
    end
  end

  // cur_q is SFX_NONE outside PLAY, so the enables decode straight from it.
  always_comb begin
    bus.enable_jump = (cur_q == SFX_JUMP);
    bus.enable_win  = (cur_q == SFX_WIN);
    bus.enable_lose = (cur_q == SFX_LOSE);
    bus.active_id   = cur_q;
    bus.busy        = (state_q != S_IDLE) || (|pend_q);
    bus.sound       = ~bus.mute & ((bus.enable_jump & bus.jump_sound_in) |
                                   (bus.enable_win  & bus.win_sound_in)  |
                                   (bus.enable_lose & bus.lose_sound_in));
  end

endmodule

// File: tb/tb_sfx_scheduler.sv
// Scoreboard bench for sfx_scheduler: directed scenarios then random events,
// checked cycle by cycle against a remaining-cycles behavioural model.
module tb_sfx_scheduler;

  localparam int J = 4;
  localparam int W = 8;
  localparam int L = 8;
  localparam int G = 2;

`ifdef SFX_PREEMPT_EN
  localparam bit Pre = 1'b1;
`else
  localparam bit Pre = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sfx_scheduler_if bus ();

  sfx_scheduler #(
    .JUMP_CYCLES (J),
    .WIN_CYCLES  (W),
    .LOSE_CYCLES (L),
    .GAP_CYCLES  (G)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       ej;
    logic       ew;
    logic       el;
    logic [1:0] id;
    logic       busy;
    logic       snd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: mode 0 idle, 1 playing, 2 gap; left = cycles remaining in that phase.
  int       m_mode = 0;
  int       m_cur  = 0;
  int       m_left = 0;
  bit       m_pj, m_pw, m_pl;
  bit [5:0] m_prev;

  // Levels for the random phase.
  bit [3:0] r_dir;
  bit       r_win, r_lose, r_mute;

  function automatic int dur(int id);
    return (id == 1) ? J : (id == 2) ? W : L;
  endfunction

  task automatic start(int id);
    m_mode = 1;
    m_cur  = id;
    m_left = dur(id);
    if (id == 1) m_pj = 0;
    if (id == 2) begin m_pw = 0; m_pj = 0; end
    if (id == 3) begin m_pl = 0; m_pj = 0; end
  endtask

  task automatic model(bit r, bit [3:0] d, bit w, bit l);
    bit je, we, le, absorb;
    int top;
    je = |(d & ~m_prev[5:2]);
    we = w & ~m_prev[1];
    le = l & ~m_prev[0];
    m_prev = {d, w, l};
    if (r) begin
      m_mode = 0; m_cur = 0; m_left = 0;
      m_pj = 0; m_pw = 0; m_pl = 0;
      return;
    end
    absorb = 0;
    top = m_pl ? 3 : m_pw ? 2 : m_pj ? 1 : 0;
    if (m_mode == 0) begin
      if (top != 0) start(top);
    end else if (m_mode == 1) begin
      if (Pre && top > m_cur) begin
        start(top);
      end else if (je && m_cur == 1) begin
        m_left = J;
        absorb = 1;
      end else begin
        m_left--;
        if (m_left == 0) begin m_mode = 2; m_cur = 0; m_left = G; end
      end
    end else begin
      m_left--;
      if (m_left == 0) m_mode = 0;
    end
    if (je && !absorb) m_pj = 1;
    if (we) m_pw = 1;
    if (le) m_pl = 1;
  endtask

  // One clock: drive inputs at the falling edge, advance the model, queue the expectation.
  task automatic tick(bit r, bit [3:0] d, bit w, bit l, bit m);
    exp_t e;
    bit [2:0] tone;
    @(negedge clk);
    tone = 3'($urandom_range(0, 7));
    reset             = r;
    bus.jump_forward  = d[3];
    bus.jump_backward = d[2];
    bus.jump_right    = d[1];
    bus.jump_left     = d[0];
    bus.win           = w;
    bus.lose          = l;
    bus.mute          = m;
    bus.jump_sound_in = tone[0];
    bus.win_sound_in  = tone[1];
    bus.lose_sound_in = tone[2];
    model(r, d, w, l);
    e.ej   = (m_mode == 1) && (m_cur == 1);
    e.ew   = (m_mode == 1) && (m_cur == 2);
    e.el   = (m_mode == 1) && (m_cur == 3);
    e.id   = (m_mode == 1) ? 2'(m_cur) : 2'd0;
    e.busy = (m_mode != 0) || m_pj || m_pw || m_pl;
    e.snd  = !m && ((e.ej && tone[0]) || (e.ew && tone[1]) || (e.el && tone[2]));
    exp_q.push_back(e);
  endtask

  task automatic idle(int n, bit m);
    for (int i = 0; i < n; i++) tick(1'b0, 4'b0, 1'b0, 1'b0, m);
  endtask

  // Monitor: compare DUT outputs just after every rising edge.
  initial begin
    exp_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got = {bus.enable_jump, bus.enable_win, bus.enable_lose, bus.active_id,
               bus.busy, bus.sound};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got {ej,ew,el,id,busy,snd}=%b required=%b",
                   $time, got, e);
        end
      end
    end
  end

  initial begin
    bus.jump_forward = 0; bus.jump_backward = 0; bus.jump_right = 0; bus.jump_left = 0;
    bus.win = 0; bus.lose = 0; bus.mute = 0;
    bus.jump_sound_in = 0; bus.win_sound_in = 0; bus.lose_sound_in = 0;

    // Reset state, then a single jump_left pulse.
    tick(1'b1, 4'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 4'b0, 1'b0, 1'b0, 1'b0);
    idle(8, 1'b0);
    tick(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
    idle(10, 1'b0);

    // win, lose and jump_forward together: lose, gap, win; jump dropped.
    tick(1'b0, 4'b1000, 1'b1, 1'b1, 1'b0);
    idle(26, 1'b0);

    // Jump retrigger while playing.
    tick(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    tick(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    idle(12, 1'b0);

    // lose in the middle of a jump.
    tick(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    tick(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    idle(20, 1'b0);

    // Reset mid-win with win held through release.
    tick(1'b0, 4'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 4'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) tick(1'b1, 4'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) tick(1'b0, 4'b0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Muted lose.
    tick(1'b0, 4'b0, 1'b0, 1'b1, 1'b1);
    idle(14, 1'b1);

    // Random events, levels, mute and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 11) == 0) r_dir[b] = ~r_dir[b];
      if ($urandom_range(0, 23) == 0) r_win = ~r_win;
      if ($urandom_range(0, 23) == 0) r_lose = ~r_lose;
      if ($urandom_range(0, 39) == 0) r_mute = ~r_mute;
      tick(($urandom_range(0, 299) == 0), r_dir, r_win, r_lose, r_mute);
    end
    idle(3, 1'b0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
